// File: rtl/cheater_msg_typer.sv
// Typewriter-reveal gate between the text renderer and the "cheater" message ROM.
// Optional blinking cursor at the reveal position: define CHEATER_CURSOR_BLINK_EN.
module cheater_msg_typer #(
    parameter int MSG_LEN         = 30,
    parameter int FRAMES_PER_CHAR = 4,
    parameter int HOLD_FRAMES     = 120
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        clear,
    input  logic        frame_tick,
    input  logic [15:0] char_xy_in,
    input  logic [6:0]  char_code_rom,
    output logic [15:0] char_xy_rom,
    output logic [6:0]  char_code_out,
    output logic        busy,
    output logic        done
);

    localparam int SHOWN_W = $clog2(MSG_LEN + 1);
    localparam int FRAME_W = (FRAMES_PER_CHAR > 1) ? $clog2(FRAMES_PER_CHAR) : 1;
    localparam int HOLD_W  = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

    localparam logic [SHOWN_W-1:0] SHOWN_FULL = SHOWN_W'(MSG_LEN);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAMES_PER_CHAR - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'((HOLD_FRAMES > 0) ? HOLD_FRAMES - 1 : 0);
    localparam logic [6:0]         SPACE_CODE = 7'h20;

    typedef enum logic [1:0] {
        IDLE,
        TYPING,
        HOLD
    } state_t;

    state_t             state_q;
    logic [SHOWN_W-1:0] shown_q;
    logic [SHOWN_W-1:0] shown_d;
    logic [FRAME_W-1:0] frame_cnt_q;
    logic [HOLD_W-1:0]  hold_cnt_q;
`ifdef CHEATER_CURSOR_BLINK_EN
    localparam logic [6:0] CURSOR_CODE = 7'h5F;
    logic [2:0] blink_q;
`endif

    assign char_xy_rom = char_xy_in;
    assign shown_d     = shown_q + SHOWN_W'(1);

    // NOTE: reset lives inside the clocked block, so it is synchronous; all state uses <=.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shown_q     <= '0;
            frame_cnt_q <= '0;
            hold_cnt_q  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef CHEATER_CURSOR_BLINK_EN
            blink_q     <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (clear) begin
                state_q     <= IDLE;
                shown_q     <= '0;
                frame_cnt_q <= '0;
                hold_cnt_q  <= '0;
                busy        <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            shown_q     <= SHOWN_W'(1);
                            frame_cnt_q <= '0;
                            hold_cnt_q  <= '0;
                            busy        <= 1'b1;
                            state_q     <= (MSG_LEN == 1) ? HOLD : TYPING;
`ifdef CHEATER_CURSOR_BLINK_EN
                            blink_q     <= '0;
`endif
                        end
                    end
                    TYPING: begin
                        if (frame_tick) begin
`ifdef CHEATER_CURSOR_BLINK_EN
                            blink_q <= blink_q + 3'd1;
`endif
                            if (frame_cnt_q == FRAME_LAST) begin
                                frame_cnt_q <= '0;
                                shown_q     <= shown_d;
                                if (shown_d == SHOWN_FULL) begin
                                    state_q    <= HOLD;
                                    hold_cnt_q <= '0;
                                end
                            end else begin
                                frame_cnt_q <= frame_cnt_q + FRAME_W'(1);
                            end
                        end
                    end
                    HOLD: begin
                        // HOLD_FRAMES == 0 keeps the banner up until clear.
                        if (frame_tick && (HOLD_FRAMES > 0)) begin
                            if (hold_cnt_q == HOLD_LAST) begin
                                state_q    <= IDLE;
                                shown_q    <= '0;
                                hold_cnt_q <= '0;
                                busy       <= 1'b0;
                                done       <= 1'b1;
                            end else begin
                                hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

    int x_col;
    int shown_col;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        char_code_out = '0;
        x_col         = int'(char_xy_in[15:8]);
        shown_col     = int'(shown_q);
        case (state_q)
            TYPING: begin
                if (x_col < shown_col) begin
                    char_code_out = char_code_rom;
                end else if (x_col < MSG_LEN) begin
                    char_code_out = SPACE_CODE;
`ifdef CHEATER_CURSOR_BLINK_EN
                    if ((x_col == shown_col) && !blink_q[2]) begin
                        char_code_out = CURSOR_CODE;
                    end
`endif
                end
            end
            HOLD: begin
                if (x_col < MSG_LEN) begin
                    char_code_out = char_code_rom;
                end
            end
            default: char_code_out = '0;
        endcase
    end

endmodule
